// File: rtl/lsu_ctrl.sv
// Load/store sequencer between the execute stage and a word-addressed synchronous data memory.
// Sub-word stores are read-modify-write; sub-word loads are sign- or zero-extended.
module lsu_ctrl #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        ready,
    output logic        done,
    output logic        misaligned,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_MERGE,
        S_WR,
        S_DONE
    } state_t;

    localparam logic [1:0] RD_LAST = 2'(RD_LAT - 1);

    state_t      r_state;
    logic        r_we;
    logic        r_uns;
    logic        r_err;
    logic [1:0]  r_size;
    logic [1:0]  r_lane;
    logic [15:0] r_wdata;
    logic [1:0]  r_cnt;
    logic [31:0] r_rdata;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;

    logic        w_mis;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_ext;
    logic [31:0] w_merged;

    // Size 11 is a word access, so bit 1 alone marks a word.
    assign w_mis = ((req_size == 2'b01) && req_addr[0]) ||
                   (req_size[1] && (req_addr[1:0] != 2'b00));

    always_comb begin
        w_byte     = mem_rdata[{r_lane, 3'b000} +: 8];
        w_half     = mem_rdata[{r_lane[1], 4'b0000} +: 16];
        w_load_ext = mem_rdata;
        w_merged   = mem_rdata;
        if (r_size == 2'b00) begin
            w_load_ext = {{24{~r_uns & w_byte[7]}}, w_byte};
            w_merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
        end else if (r_size == 2'b01) begin
            w_load_ext = {{16{~r_uns & w_half[15]}}, w_half};
            w_merged[{r_lane[1], 4'b0000} +: 16] = r_wdata;
        end
    end

    // Sequencer: the merged word is registered on the last read edge so the
    // write in MERGE does not depend on the memory holding its read output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_uns       <= 1'b0;
            r_err       <= 1'b0;
            r_size      <= 2'b00;
            r_lane      <= 2'b00;
            r_wdata     <= 16'h0;
            r_cnt       <= 2'b00;
            r_rdata     <= 32'h0;
            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_we    <= req_we;
                        r_size  <= req_size;
                        r_uns   <= req_unsigned;
                        r_lane  <= req_addr[1:0];
                        r_wdata <= req_wdata[15:0];
                        r_err   <= w_mis;
                        r_cnt   <= 2'b00;
                        if (w_mis) begin
                            r_state <= S_DONE;
                        end else begin
                            r_mem_addr <= {req_addr[31:2], 2'b00};
                            if (req_we && req_size[1]) begin
                                r_mem_wdata <= req_wdata;
                                r_state     <= S_WR;
                            end else begin
                                r_state <= S_RD;
                            end
                        end
                    end
                end
                S_RD: begin
                    if (r_cnt == RD_LAST) begin
                        r_cnt <= 2'b00;
                        if (r_we) begin
                            r_mem_wdata <= w_merged;
                            r_state     <= S_MERGE;
                        end else begin
                            r_rdata <= w_load_ext;
                            r_state <= S_DONE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                S_MERGE: r_state <= S_DONE;
                S_WR:    r_state <= S_DONE;
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ready      = (r_state == S_IDLE);
    assign done       = (r_state == S_DONE);
    assign misaligned = (r_state == S_DONE) && r_err;
    assign mem_we     = (r_state == S_MERGE) || (r_state == S_WR);
    assign rdata      = r_rdata;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store sequencer for the datapath's data-memory port. It accepts one load or store request at a time from the CPU core and drives the word-addressed synchronous data memory: it presents the address, writes data, and captures read data. Byte and halfword stores are done as read-modify-write, and byte/halfword loads are sign- or zero-extended. It sits between the execute stage and the data memory; the memory sees only word reads and word writes.

## Interface
Parameters:
- RD_LAT, 1, cycles from presenting `mem_addr` (with `mem_we`=0) until `mem_rdata` is valid; legal range 1..4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (low = reset).
- req  in  1  request valid; accepted on a rising edge while `ready`=1.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word; 11 is treated as word.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- ready  out  1  1 only in IDLE.
- done  out  1  one-cycle completion pulse.
- misaligned  out  1  pulses together with `done` when the request was rejected.
- rdata  out  32  extended load result; held until the next completed load.
- mem_addr  out  32  word address; bits [1:0] are always 00.
- mem_wdata  out  32  word write data.
- mem_we  out  1  memory write enable; the memory commits on the rising edge.
- mem_rdata  in  32  memory read data.

## Operation
- States: IDLE, RD, MERGE, WR, DONE.
- **IDLE**
  - `ready`=1.
  - On `req`, latch addr, size, we, unsigned flag and wdata.
  - A halfword with addr[0]=1, or a word with addr[1:0]≠00, is misaligned. It goes to DONE with the error flag set and makes no memory access.
  - A word store goes to WR.
  - All other requests go to RD.
- **RD**
  - Drive `mem_addr`={addr[31:2],2'b00}, with `mem_we`=0.
  - Stay for RD_LAT cycles, counted by an internal counter.
  - On the last RD edge:
    - a load captures the extended lane from `mem_rdata` into `rdata` and goes to DONE;
    - a sub-word store goes to MERGE.
- **MERGE**
  - `mem_we`=1, with the same `mem_addr`.
  - `mem_wdata` = `mem_rdata` with the addressed lane replaced by the right-aligned `req_wdata` lane.
  - Then go to DONE.
- **WR**
  - `mem_we`=1, `mem_wdata`=latched wdata.
  - Then go to DONE.
- **DONE**
  - `done`=1; `misaligned`=error flag.
  - Always go to IDLE on the next edge. There is no back-to-back accept.
- Lane selection is little-endian:
  - byte k = addr[1:0] occupies bits [8k+7:8k];
  - half h = addr[1] occupies bits [16h+15:16h].
- Extension:
  - sign: replicate the lane MSB up to bit 31;
  - unsigned: zero-fill.
  - `req_unsigned` is ignored for word accesses and for stores.
- `rdata` changes only on a completed aligned load. Stores and misaligned requests leave it unchanged.
- Request inputs are ignored outside IDLE.

## Timing
- Reset values (while `rst`=0):
  - state IDLE, so `ready`=1;
  - `done`=0, `misaligned`=0, `mem_we`=0;
  - `mem_addr`=0, `mem_wdata`=0, `rdata`=0;
  - RD counter 0.
- `mem_we`, `done`, `misaligned` and `ready` decode directly from the state register, so reset forces them inactive immediately.
- Latencies, counted as cycles from the accept edge to the `done` cycle:
  - load: RD_LAT+1;
  - word store: 2;
  - sub-word store: RD_LAT+2;
  - misaligned: 1.
- `mem_we` is high for exactly one cycle per store and never for loads or misaligned requests.
- `mem_addr` is stable from the first RD/WR cycle through MERGE/WR.
- Reset mid-operation: the in-flight request is dropped, with no `done` and no partial write. If `rst` falls before the MERGE/WR edge, memory is unchanged.
- `req_size`=11 behaves exactly like 10.

## Test plan
Preload memory word 0x10 = 0x8899AABB. Use RD_LAT=1 unless stated.

- LW 0x10 → `done` 2 cycles after accept; `rdata`=0x8899AABB; `mem_we` stays 0.
- Loads from 0x13 and 0x10–0x12:
  - LB 0x13 → 0xFFFFFF88;
  - LBU 0x13 → 0x00000088;
  - LH 0x10 → 0xFFFFAABB;
  - LHU 0x12 → 0x00008899.
- SB 0x11, wdata 0x12345677 → one `mem_we` cycle with `mem_wdata`=0x889977BB; a following LW 0x10 returns 0x889977BB. `done` 3 cycles after accept.
- SW 0x20, wdata 0xDEADBEEF → `done` 2 cycles after accept; exactly one `mem_we` cycle with `mem_addr`=0x20.
- LH 0x11 → `done`=`misaligned`=1 one cycle after accept; no `mem_we`; `rdata` unchanged.
- SH 0x12, wdata 0x0000CAFE, `rst` driven low during MERGE → memory word 0x10 unchanged, `ready`=1, `rdata`=0.
- With RD_LAT=3: LW 0x10 → `done` 4 cycles after accept; `mem_addr` held for 3 RD cycles.
